exec_ccr_ctrl: RTL and testbench
================================

// Module: exec_ccr_ctrl
// PURPOSE
//  Condition-code controller for the execute stage. Owns the architectural CCR {C,N,Z} and decides,
//  per ALU op, which ALU status bits commit. Handles SETC/CLRC and stall/flush, and saves/restores
//  the CCR on interrupt entry (INT) and return (RTI) via a small LIFO. Sits between the ALU status
//  output and the branch unit.
// PARAMETERS
//  SAVE_DEPTH  4  LIFO entries for nested-interrupt CCR saves (power of 2, >=2)
//  PTR_W       2  log2(SAVE_DEPTH)
// PORTS
//  clk         in   1      clock, rising edge
//  rst_n       in   1      asynchronous active-low reset
//  ex_valid    in   1      ALU op in EX is valid this cycle
//  alu_ctrl    in   4      ALU opcode in EX (0000 ADD .. 1010 PASS1)
//  alu_status  in   4      ALU status: [3] written marker, [2] C, [1] N, [0] Z
//  stall       in   1      pipeline stall: no commit, FSM holds
//  flush       in   1      squash EX op: no ALU commit this cycle
//  setc        in   1      SETC instruction in EX
//  clrc        in   1      CLRC instruction in EX
//  int_req     in   1      interrupt accepted by front end (level, held until int_ack)
//  rti         in   1      RTI in EX (single-cycle pulse)
//  ccr         out  3      registered {C,N,Z}
//  ccr_fwd     out  3      flags for branch unit this cycle (see CONFIGURATION)
//  int_ack     out  1      1-cycle pulse: CCR pushed
//  busy        out  1      FSM not in RUN; front end must stall
//  save_ovf    out  1      sticky: push attempted while LIFO full
//  save_unf    out  1      sticky: RTI while LIFO empty
// BEHAVIOUR
//  Reset (async, rst_n=0): ccr=000, LIFO ptr=0, FSM=RUN, int_ack=0, busy=0, save_ovf=0, save_unf=0.
//  Commit mask by alu_ctrl: ADD/SUB/SHL/SHR/INC/DEC(0000,0001,0100,0101,1000,1001)->C,N,Z;
//   AND/OR/NOT(0010,0011,0110)->N,Z only; PASS2/PASS1(0111,1010)->none; 1011-1111 decode as ADD.
//  ALU commit when ex_valid & ~stall & ~flush & alu_status[3] & FSM==RUN. Masked bits keep value.
//  Same-cycle priority: RESTORE write > CLRC > SETC > ALU commit. setc&clrc together -> C=0.
//   SETC/CLRC override C only; N,Z still commit from the ALU per mask. Latency: ccr updates 1 cycle.
//  FSM RUN/SAVE/RESTORE:
//   RUN: rti & ~stall -> RESTORE; else int_req & ~stall -> SAVE; rti wins if both.
//   SAVE (1 cycle): push ccr (includes any commit from entry cycle); ptr++; int_ack=1;
//    ccr unchanged; -> RUN. LIFO full: no push, ptr holds, save_ovf<=1, int_ack still pulses.
//   RESTORE (1 cycle): ccr<=LIFO[ptr-1]; ptr--; ALU/SETC/CLRC ignored; -> RUN.
//    LIFO empty: ccr unchanged, save_unf<=1.
//   busy=1 in SAVE and RESTORE. stall in SAVE/RESTORE does not extend them (internal op).
//  Wrap: ptr never wraps; saturates at 0 and SAVE_DEPTH. Reset mid-SAVE/RESTORE aborts to RUN, LIFO cleared.
//  flush does not cancel a pending SAVE/RESTORE already entered.
// CONFIGURATION
//  CCR_FWD_EN defined: ccr_fwd = next-state CCR (combinational bypass of this cycle's commit,
//   SETC/CLRC and restore) for zero-bubble branch-after-ALU.
//  CCR_FWD_EN undefined: ccr_fwd = ccr (registered); branch must be 1 cycle after the setter.
// STRUCTURE
//  Shared package ccr_pkg: ALU opcode localparams (ALU_ADD..ALU_PASS1), CCR bit indices
//   (CCR_C=2, CCR_N=1, CCR_Z=0), FSM state enum (ST_RUN, ST_SAVE, ST_RESTORE), flag_mask function.
//  Sub-module ccr_save_lifo (push/pop/full/empty, SAVE_DEPTH x 3 bit); FSM, mask, priority in top.
// TESTING
//  1 ADD, alu_status=4'b1101, ex_valid=1 -> next cycle ccr=101; AND status 4'b1010 -> ccr=110.
//  2 ccr=111, PASS2 status 4'b1001 -> ccr stays 111; flush=1 with ADD -> ccr unchanged.
//  3 setc+clrc same cycle with SUB status 4'b1110 -> ccr=010 (C=0, N=1, Z=0).
//  4 ccr=011, int_req -> SAVE: int_ack 1 pulse, busy=1; ccr=000 via ALU; rti -> ccr=011 after RESTORE.
//  5 SAVE_DEPTH+1 nested int_req -> save_ovf=1 on last; SAVE_DEPTH+1 rti -> save_unf=1, ccr held.
//  6 rst_n low mid-RESTORE -> ccr=000, busy=0 immediately; with CCR_FWD_EN, ADD 4'b1001 -> ccr_fwd=001 same cycle.

Source files
------------

// File: rtl/ccr_pkg.sv
// Shared definitions for the execute-stage condition-code controller:
// ALU opcodes, CCR bit positions, controller states and the per-opcode
// flag commit mask.
package ccr_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_SHL   = 4'b0100;
  localparam logic [3:0] ALU_SHR   = 4'b0101;
  localparam logic [3:0] ALU_NOT   = 4'b0110;
  localparam logic [3:0] ALU_PASS2 = 4'b0111;
  localparam logic [3:0] ALU_INC   = 4'b1000;
  localparam logic [3:0] ALU_DEC   = 4'b1001;
  localparam logic [3:0] ALU_PASS1 = 4'b1010;

  localparam int CCR_C = 2;
  localparam int CCR_N = 1;
  localparam int CCR_Z = 0;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2
  } state_t;

  // Which CCR bits an ALU op is allowed to write, laid out as {C,N,Z}.
  // Logic ops leave carry alone, pass-through ops touch nothing, and
  // unused opcodes behave like ADD.
  function automatic logic [2:0] flag_mask(input logic [3:0] op);
    logic [2:0] m;
    case (op)
      ALU_AND, ALU_OR, ALU_NOT: m = 3'b011;
      ALU_PASS2, ALU_PASS1:     m = 3'b000;
      default:                  m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ccr_save_lifo.sv
// Small LIFO holding saved CCR values across nested interrupts.
// The pointer counts occupied entries and saturates at 0 and SAVE_DEPTH:
// a push when full and a pop when empty are simply ignored, and the
// caller is responsible for flagging them.
module ccr_save_lifo #(
  parameter int SAVE_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [2:0] din,
  output logic [2:0] dout,
  output logic       full,
  output logic       empty
);

  logic [PTR_W:0]   ptr;
  logic [PTR_W:0]   top;
  logic [2:0]       mem [SAVE_DEPTH];

  assign full  = (ptr == (PTR_W+1)'(SAVE_DEPTH));
  assign empty = (ptr == '0);
  assign top   = ptr - 1'b1;
  assign dout  = empty ? 3'b000 : mem[top[PTR_W-1:0]];

  // Pointer and storage update; reset empties the stack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      for (int i = 0; i < SAVE_DEPTH; i++) mem[i] <= 3'b000;
    end else if (push && !full) begin
      mem[ptr[PTR_W-1:0]] <= din;
      ptr                 <= ptr + 1'b1;
    end else if (pop && !empty) begin
      ptr <= ptr - 1'b1;
    end
  end

endmodule

// File: rtl/exec_ccr_ctrl.sv
// Execute-stage condition-code controller. Owns the architectural CCR
// {C,N,Z}, applies per-opcode commit masks, SETC/CLRC, and saves/restores
// the CCR through a LIFO on interrupt entry and RTI.
// Optional build macro CCR_FWD_EN: ccr_fwd bypasses this cycle's update;
// without it ccr_fwd is the registered CCR.
module exec_ccr_ctrl
  import ccr_pkg::*;
#(
  parameter int SAVE_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ex_valid,
  input  logic [3:0] alu_ctrl,
  input  logic [3:0] alu_status,
  input  logic       stall,
  input  logic       flush,
  input  logic       setc,
  input  logic       clrc,
  input  logic       int_req,
  input  logic       rti,
  output logic [2:0] ccr,
  output logic [2:0] ccr_fwd,
  output logic       int_ack,
  output logic       busy,
  output logic       save_ovf,
  output logic       save_unf
);

  state_t     state;
  logic [2:0] ccr_next;
  logic [2:0] mask;
  logic       alu_commit;
  logic       c_op_ok;
  logic       lifo_push;
  logic       lifo_pop;
  logic [2:0] lifo_dout;
  logic       lifo_full;
  logic       lifo_empty;

  assign mask       = flag_mask(alu_ctrl);
  assign alu_commit = ex_valid && !stall && !flush && alu_status[3] && (state == ST_RUN);
  // SETC/CLRC are EX instructions too: a stall holds them, a flush kills them.
  assign c_op_ok    = !stall && !flush && (state == ST_RUN);
  assign lifo_push  = (state == ST_SAVE);
  assign lifo_pop   = (state == ST_RESTORE);

  // Next CCR: restore beats everything, then CLRC > SETC on C, then ALU per mask.
  always_comb begin
    ccr_next = ccr;
    if (state == ST_RESTORE) begin
      if (!lifo_empty) ccr_next = lifo_dout;
    end else if (state == ST_RUN) begin
      if (alu_commit) ccr_next = (ccr & ~mask) | (alu_status[2:0] & mask);
      if (c_op_ok) begin
        if (clrc)      ccr_next[CCR_C] = 1'b0;
        else if (setc) ccr_next[CCR_C] = 1'b1;
      end
    end
  end

  // Architectural CCR register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ccr <= 3'b000;
    else        ccr <= ccr_next;
  end

  // Save/restore sequencer with registered handshake and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      int_ack  <= 1'b0;
      busy     <= 1'b0;
      save_ovf <= 1'b0;
      save_unf <= 1'b0;
    end else begin
      int_ack <= 1'b0;
      case (state)
        ST_RUN: begin
          if (rti && !stall) begin
            state <= ST_RESTORE;
            busy  <= 1'b1;
          end else if (int_req && !stall) begin
            state   <= ST_SAVE;
            busy    <= 1'b1;
            int_ack <= 1'b1;
          end
        end
        ST_SAVE: begin
          state <= ST_RUN;
          busy  <= 1'b0;
          if (lifo_full) save_ovf <= 1'b1;
        end
        ST_RESTORE: begin
          state <= ST_RUN;
          busy  <= 1'b0;
          if (lifo_empty) save_unf <= 1'b1;
        end
        default: begin
          state <= ST_RUN;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CCR_FWD_EN
  assign ccr_fwd = ccr_next;
`else
  assign ccr_fwd = ccr;
`endif

  ccr_save_lifo #(
    .SAVE_DEPTH (SAVE_DEPTH),
    .PTR_W      (PTR_W)
  ) u_lifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (lifo_push),
    .pop   (lifo_pop),
    .din   (ccr),
    .dout  (lifo_dout),
    .full  (lifo_full),
    .empty (lifo_empty)
  );

endmodule

// File: tb/tb_exec_ccr_ctrl.sv
// Bench for exec_ccr_ctrl: directed scenarios plus randomized traffic,
// each cycle compared against a behavioural model built on a queue stack.
module tb_exec_ccr_ctrl;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ex_valid, stall, flush, setc, clrc, int_req, rti;
  logic [3:0] alu_ctrl, alu_status;
  logic [2:0] ccr, ccr_fwd;
  logic       int_ack, busy, save_ovf, save_unf;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  logic [2:0] m_ccr;
  logic [2:0] m_stack [$];
  int         m_phase;      // 0 running, 1 saving, 2 restoring
  logic       m_ovf, m_unf;
  logic       ir_hold;

  always #5 clk = ~clk;

  exec_ccr_ctrl #(.SAVE_DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .alu_ctrl(alu_ctrl),
    .alu_status(alu_status), .stall(stall), .flush(flush), .setc(setc),
    .clrc(clrc), .int_req(int_req), .rti(rti), .ccr(ccr), .ccr_fwd(ccr_fwd),
    .int_ack(int_ack), .busy(busy), .save_ovf(save_ovf), .save_unf(save_unf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] model_mask(input logic [3:0] op);
    if (op inside {4'd2, 4'd3, 4'd6}) return 3'b011;
    if (op inside {4'd7, 4'd10})      return 3'b000;
    return 3'b111;
  endfunction

  task automatic model_clear();
    m_ccr = 3'b000;
    m_stack.delete();
    m_phase = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    ir_hold = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ex_valid = 0; alu_ctrl = 0; alu_status = 0; stall = 0; flush = 0;
    setc = 0; clrc = 0; int_req = 0; rti = 0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive at negedge, check outputs against the model, then
  // advance the model at the rising edge.
  task automatic cycle(input logic v, input logic [3:0] op, input logic [3:0] st,
                       input logic stl, input logic fl, input logic sc, input logic cc,
                       input logic ir, input logic rt);
    logic [2:0] n_ccr;
    int         n_phase;
    logic [2:0] fwd_exp;
    @(negedge clk);
    ex_valid = v; alu_ctrl = op; alu_status = st; stall = stl; flush = fl;
    setc = sc; clrc = cc; int_req = ir; rti = rt;
    #1;
    n_ccr   = m_ccr;
    n_phase = 0;
    if (m_phase == 2) begin
      if (m_stack.size() > 0) n_ccr = m_stack.pop_back();
      else m_unf = 1'b1;
    end else if (m_phase == 1) begin
      if (m_stack.size() < DEPTH) m_stack.push_back(m_ccr);
      else m_ovf = 1'b1;
    end else begin
      if (v && !stl && !fl && st[3]) begin
        for (int b = 0; b < 3; b++)
          if (model_mask(op)[b]) n_ccr[b] = st[b];
      end
      if (!stl && !fl && (sc || cc)) n_ccr[2] = !cc;
      if (rt && !stl)      n_phase = 2;
      else if (ir && !stl) n_phase = 1;
    end
`ifdef CCR_FWD_EN
    fwd_exp = n_ccr;
`else
    fwd_exp = m_ccr;
`endif
    chk("ccr", 32'(ccr), 32'(m_ccr));
    chk("ccr_fwd", 32'(ccr_fwd), 32'(fwd_exp));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("int_ack", 32'(int_ack), 32'(m_phase == 1));
    @(posedge clk);
    m_ccr   = n_ccr;
    m_phase = n_phase;
    #1;
    chk("save_ovf", 32'(save_ovf), 32'(m_ovf));
    chk("save_unf", 32'(save_unf), 32'(m_unf));
  endtask

  task automatic alu(input logic [3:0] op, input logic [3:0] st);
    cycle(1'b1, op, st, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle();
    cycle(1'b0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    do_reset();
    chk("rst_ccr", 32'(ccr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(int_ack), 32'd0);
    chk("rst_ovf", 32'(save_ovf), 32'd0);
    chk("rst_unf", 32'(save_unf), 32'd0);

    // ADD then AND
    alu(4'b0000, 4'b1101);
    chk("t1_add", 32'(ccr), 32'b101);
    alu(4'b0010, 4'b1010);
    chk("t1_and", 32'(ccr), 32'b110);

    // PASS2 and flushed ADD leave CCR alone; unwritten status ignored
    alu(4'b0000, 4'b1111);
    alu(4'b0111, 4'b1001);
    chk("t2_pass2", 32'(ccr), 32'b111);
    cycle(1, 4'b0000, 4'b1000, 0, 1, 0, 0, 0, 0);
    chk("t2_flush", 32'(ccr), 32'b111);
    alu(4'b0000, 4'b0000);
    chk("t2_nomark", 32'(ccr), 32'b111);
    alu(4'b1100, 4'b1000);
    chk("t2_op1100", 32'(ccr), 32'b000);

    // SETC and CLRC together
    cycle(1, 4'b0001, 4'b1110, 0, 0, 1, 1, 0, 0);
    chk("t3_setclr", 32'(ccr), 32'b010);

    // interrupt save, ALU change, RTI restore
    alu(4'b0000, 4'b1011);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("t4_ack", 32'(int_ack), 32'd1);
    chk("t4_busy", 32'(busy), 32'd1);
    idle();
    chk("t4_ack_off", 32'(int_ack), 32'd0);
    alu(4'b0000, 4'b1000);
    chk("t4_zero", 32'(ccr), 32'b000);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    chk("t4_restore", 32'(ccr), 32'b011);

    // nesting beyond the stack depth, then unwinding past empty
    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      logic [2:0] s;
      s = 3'(i + 1);
      cycle(1, 4'b0000, {1'b1, s}, 0, 0, 0, 0, 1, 0);
      idle();
      if (i == DEPTH - 1) chk("t5_noovf", 32'(save_ovf), 32'd0);
    end
    chk("t5_ovf", 32'(save_ovf), 32'd1);
    for (int i = 0; i <= DEPTH; i++) begin
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle();
      if (i == DEPTH - 1) chk("t5_nounf", 32'(save_unf), 32'd0);
    end
    chk("t5_unf", 32'(save_unf), 32'd1);
    chk("t5_held", 32'(ccr), 32'b001);

    // reset in the middle of a restore
    do_reset();
    alu(4'b0000, 4'b1111);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_ccr", 32'(ccr), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    do_reset();
`ifdef CCR_FWD_EN
    @(negedge clk);
    ex_valid = 1; alu_ctrl = 4'b0000; alu_status = 4'b1001;
    #1;
    chk("t6_fwd", 32'(ccr_fwd), 32'b001);
`endif

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic v, stl, fl, sc, cc, rt;
      logic [3:0] op, st;
      v   = ($urandom_range(0, 3) != 0);
      op  = 4'($urandom_range(0, 15));
      st  = 4'($urandom_range(0, 15));
      stl = ($urandom_range(0, 4) == 0);
      fl  = ($urandom_range(0, 6) == 0);
      sc  = !fl && ($urandom_range(0, 9) == 0);
      cc  = !fl && ($urandom_range(0, 9) == 0);
      rt  = ($urandom_range(0, 15) == 0);
      if (ir_hold && m_phase == 1) ir_hold = 1'b0;
      else if (!ir_hold && $urandom_range(0, 15) == 0) ir_hold = 1'b1;
      cycle(v, op, st, stl, fl, sc, cc, ir_hold, rt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
